// File: rtl/clk_gen_pkg.sv
// clk_gen_pkg
//   Shared definitions for the clock-enable generator slice:
//   - rst_state_e : states of the downstream reset sequencer
//   - *_DFLT      : default values for DEF_DIV, SB_DIV and RST_HOLD
//   - clog2_min1  : $clog2 clamped to at least 1 bit, so that degenerate
//                   parameter values never produce zero-width vectors
package clk_gen_pkg;

  // Reset sequencer states. S_HOLD keeps rst_out_n low while sideband
  // ticks are counted; S_RUN releases the downstream reset.
  typedef enum logic {
    S_HOLD = 1'b0,
    S_RUN  = 1'b1
  } rst_state_e;

  localparam int DEF_DIV_DFLT  = 1;
  localparam int SB_DIV_DFLT   = 80;
  localparam int RST_HOLD_DFLT = 3;

  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/clk_div_ch.sv
// clk_div_ch
//   One tick channel: a divide-ratio register plus a 0..div-1 counter that
//   emits a registered one-cycle tick each time the counter wraps.
//
// Ports
//   clk      in   channel clock (rising edge)
//   rst      in   synchronous, active-low reset (div -> DEF_DIV, count -> 0)
//   en       in   channel enable; low holds the counter and tick at 0
//   restart  in   one-cycle strobe: count restarts from 0 this edge
//   load     in   one-cycle strobe: latch load_div as the new divide ratio
//   load_div in   new divide ratio (0 disables the channel)
//   tick     out  registered one-cycle strobe, every div cycles
//
// Timing: after a restart at edge W the first tick is registered at edge
// W+div. A channel that was idle (disabled or just out of reset) sits at
// count 0, so with en sampled high from edge X onward its first tick is
// registered at edge X+div-1, i.e. in the div-th enabled cycle.
module clk_div_ch
  #(
    parameter int DIV_W   = 8,
    parameter int DEF_DIV = 1
  )
  (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             restart,
    input  logic             load,
    input  logic [DIV_W-1:0] load_div,
    output logic             tick
  );

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;
  logic             running;

  // The check uses the divide ratio in force before this edge. A write
  // always comes with a restart, so a ratio change never sees a stale
  // count compared against the new ratio.
  assign running = en && (div_q != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q <= DIV_W'(DEF_DIV);
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      if (load) begin
        div_q <= load_div;
      end

      if (restart || !running) begin
        cnt_q <= '0;
        tick  <= 1'b0;
      end else if (cnt_q == (div_q - DIV_W'(1))) begin
        cnt_q <= '0;
        tick  <= 1'b1;
      end else begin
        cnt_q <= cnt_q + DIV_W'(1);
        tick  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_enable_gen.sv
// clk_enable_gen
//   Clock-enable generator for a single local_clk domain:
//   - N_CH independent tick channels with programmable divide ratios
//   - a free-running sideband tick every SB_DIV cycles
//   - a sequenced downstream reset (rst_out_n) released RST_HOLD sideband
//     ticks after reset or after a soft reset request
//
// Ports
//   local_clk     in   sole clock, rising edge
//   rst           in   synchronous, active-low reset; overrides all inputs
//   cfg_wr        in   one-cycle write strobe for a channel divide ratio
//   cfg_ch        in   target channel of cfg_wr; values >= N_CH are ignored
//   cfg_div       in   new divide ratio; 0 disables the channel
//   ch_en         in   per-channel enable
//   sync_req      in   one-cycle strobe restarting every channel counter
//   soft_rst_req  in   one-cycle strobe re-running the reset release
//   ch_tick       out  registered one-cycle tick per channel
//   sb_tick       out  registered one-cycle sideband tick
//   rst_out_n     out  registered, sequenced active-low downstream reset
//   dbg_state     out  current reset sequencer state (rst_state_e encoding)
//
// All strobe inputs are single-cycle requests acted on at the edge where
// they are sampled high; there is no backpressure and no acknowledge, so a
// request held high for several cycles is acted on once per cycle.
//
// RST_HOLD must be at least 1.
module clk_enable_gen
  import clk_gen_pkg::*;
  #(
    parameter int N_CH     = 3,
    parameter int DIV_W    = 8,
    parameter int DEF_DIV  = DEF_DIV_DFLT,
    parameter int SB_DIV   = SB_DIV_DFLT,
    parameter int RST_HOLD = RST_HOLD_DFLT
  )
  (
    input  logic                        local_clk,
    input  logic                        rst,
    input  logic                        cfg_wr,
    input  logic [clog2_min1(N_CH)-1:0] cfg_ch,
    input  logic [DIV_W-1:0]            cfg_div,
    input  logic [N_CH-1:0]             ch_en,
    input  logic                        sync_req,
    input  logic                        soft_rst_req,
    output logic [N_CH-1:0]             ch_tick,
    output logic                        sb_tick,
    output logic                        rst_out_n,
    output logic                        dbg_state
  );

  localparam int CH_W   = clog2_min1(N_CH);
  localparam int SB_W   = clog2_min1(SB_DIV);
  localparam int HOLD_W = clog2_min1(RST_HOLD + 1);

  // ---------------------------------------------------------------------
  // Tick channels
  // ---------------------------------------------------------------------
  // cfg_ch is wider than needed when N_CH is not a power of two; the
  // out-of-range codes must not touch any channel.
  logic cfg_hit;

  assign cfg_hit = cfg_wr && (32'(cfg_ch) < 32'(N_CH));

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic sel;

    assign sel = cfg_hit && (cfg_ch == CH_W'(i));

    // A write restarts only its own channel; sync_req restarts all of
    // them. Both together still load the ratio and restart once.
    clk_div_ch #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk      (local_clk),
      .rst      (rst),
      .en       (ch_en[i]),
      .restart  (sync_req | sel),
      .load     (sel),
      .load_div (cfg_div),
      .tick     (ch_tick[i])
    );
  end

  // ---------------------------------------------------------------------
  // Sideband tick: free-running from reset, blind to every other strobe.
  // The first tick is registered at the SB_DIV-th edge after reset release.
  // ---------------------------------------------------------------------
  logic [SB_W-1:0] sb_cnt;

  always_ff @(posedge local_clk) begin
    if (!rst) begin
      sb_cnt  <= '0;
      sb_tick <= 1'b0;
    end else if (sb_cnt == SB_W'(SB_DIV - 1)) begin
      sb_cnt  <= '0;
      sb_tick <= 1'b1;
    end else begin
      sb_cnt  <= sb_cnt + SB_W'(1);
      sb_tick <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Downstream reset sequencer
  // ---------------------------------------------------------------------
  // The FSM counts the registered sb_tick, so the release lands in the
  // cycle after the RST_HOLD-th pulse. A soft reset request wins over a
  // pulse seen in the same cycle: the hold count restarts from zero.
  rst_state_e       state;
  logic [HOLD_W-1:0] hold_cnt;

  assign dbg_state = state;

  always_ff @(posedge local_clk) begin
    if (!rst) begin
      state     <= S_HOLD;
      hold_cnt  <= '0;
      rst_out_n <= 1'b0;
    end else begin
      case (state)
        S_HOLD: begin
          rst_out_n <= 1'b0;
          if (soft_rst_req) begin
            hold_cnt <= '0;
          end else if (sb_tick) begin
            if (hold_cnt == HOLD_W'(RST_HOLD - 1)) begin
              state     <= S_RUN;
              hold_cnt  <= '0;
              rst_out_n <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
        end

        S_RUN: begin
          if (soft_rst_req) begin
            state     <= S_HOLD;
            hold_cnt  <= '0;
            rst_out_n <= 1'b0;
          end else begin
            rst_out_n <= 1'b1;
          end
        end

        default: begin
          state     <= S_HOLD;
          hold_cnt  <= '0;
          rst_out_n <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/clk_enable_gen.md
CLK_ENABLE_GEN -- requirements
Module: clk_enable_gen

Interface
REQ-001 Parameter N_CH, default 3: number of independent tick channels (gen2/gen3/gen4 rates).
REQ-002 Parameter DIV_W, default 8: width of each channel divide ratio.
REQ-003 Parameter DEF_DIV, default 1: divide ratio loaded into every channel at reset.
REQ-004 Parameter SB_DIV, default 80: local_clk cycles per sideband tick.
REQ-005 Parameter RST_HOLD, default 3: sideband ticks for which rst_out_n is held low.
REQ-006 local_clk  in  1  sole clock; every register samples on its rising edge.
REQ-007 rst  in  1  synchronous, active-low reset.
REQ-008 cfg_wr  in  1  one-cycle write strobe for a channel divide ratio.
REQ-009 cfg_ch  in  $clog2(N_CH)  target channel of cfg_wr.
REQ-010 cfg_div  in  DIV_W  new divide ratio; 0 disables the channel.
REQ-011 ch_en  in  N_CH  per-channel enable.
REQ-012 sync_req  in  1  one-cycle strobe that realigns all channel counters.
REQ-013 soft_rst_req  in  1  one-cycle strobe that re-runs the reset-release sequence.
REQ-014 ch_tick  out  N_CH  registered one-cycle strobe per channel.
REQ-015 sb_tick  out  1  registered one-cycle sideband strobe.
REQ-016 rst_out_n  out  1  registered, sequenced active-low reset for downstream layers.

Function
REQ-017 Each channel shall count 0..div-1 and assert ch_tick[i] in the div-th cycle after its last restart, then every div cycles.
REQ-018 div=1 shall give ch_tick[i] high every cycle.
REQ-019 div=0 or ch_en[i]=0 shall hold that counter at 0 and ch_tick[i] at 0.
REQ-020 Re-enabling a channel shall restart its count from 0.
REQ-021 cfg_wr with cfg_ch<N_CH shall latch cfg_div and restart that channel's count, so the first new tick falls cfg_div cycles after the write cycle.
REQ-022 Other channels shall be unaffected by a write.
REQ-023 cfg_wr with cfg_ch>=N_CH shall be ignored.
REQ-024 sync_req shall restart all channel counters in the same cycle.
REQ-025 When sync_req and cfg_wr coincide, the div update shall still be applied and all counters shall restart once.
REQ-026 sb_tick shall free-run from reset and assert once every SB_DIV cycles, first in cycle SB_DIV.
REQ-027 The sb_tick counter shall not be affected by sync_req, cfg_wr or soft_rst_req.
REQ-028 The reset sequencer shall be a two-state FSM:
- S_HOLD: rst_out_n=0; count sb_tick pulses; move to S_RUN in the cycle after the RST_HOLD-th pulse.
- S_RUN: rst_out_n=1; move to S_HOLD on soft_rst_req, with the hold count cleared.
REQ-029 soft_rst_req received in S_HOLD shall clear the hold count, extending the hold.
REQ-030 Channel ticks shall run regardless of FSM state.

Reset
REQ-031 With rst=0 at a clock edge, the block shall set:
- all counters to 0;
- every div to DEF_DIV;
- ch_tick, sb_tick and rst_out_n to 0;
- FSM to S_HOLD.
REQ-032 Reset asserted mid-operation shall take effect at the next edge and override all other inputs.
REQ-033 Counting shall begin with the first edge at which rst=1 is sampled (cycle 1).

Structure
REQ-034 The package clk_gen_pkg shall hold the FSM state enum and the default values of DEF_DIV, SB_DIV and RST_HOLD.
REQ-035 One sub-module, clk_div_ch (a single channel counter plus div register), shall be instantiated N_CH times via generate.

Verification
REQ-036 The bench shall cover the following directed scenarios:
- Divs 1/2/4 written, ch_en=3'b111, 8 cycles -> tick counts 8/4/2.
- Channel 1 at div=4, write cfg_div=5 mid-count -> next ch_tick[1] exactly 5 cycles after the write; ch 0/2 unchanged.
- Channels at divs 3/3/3 misaligned, pulse sync_req -> all three tick together 3 cycles later and every 3 thereafter.
- SB_DIV=4, RST_HOLD=3 after reset -> sb_tick in cycles 4/8/12; rst_out_n rises in cycle 13.
- soft_rst_req in S_RUN -> rst_out_n low next cycle, high again after 3 more sb_tick pulses; cfg_ch=3 (N_CH=3) write -> no change.
- div=0 or ch_en=0 -> no ticks; rst=0 mid-count -> all outputs 0 next cycle, divs back to DEF_DIV.
